// File: rtl/s2mm_cmd_sched_if.sv
// Datamover command and status streams between the scheduler and the S2MM datamover.
// Handshake: a beat moves on a rising clock edge where tvalid && tready are both 1;
// once tvalid is raised, tdata holds steady and tvalid stays high until that beat moves.
interface s2mm_cmd_sched_if;
    logic [71:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic [7:0]  s_axis_sts_tdata;
    logic        s_axis_sts_tvalid;
    logic        s_axis_sts_tready;

    // Scheduler side: drives commands, consumes status
    modport master (
        output m_axis_cmd_tdata,
        output m_axis_cmd_tvalid,
        input  m_axis_cmd_tready,
        input  s_axis_sts_tdata,
        input  s_axis_sts_tvalid,
        output s_axis_sts_tready
    );

    // Datamover side: consumes commands, produces status
    modport slave (
        input  m_axis_cmd_tdata,
        input  m_axis_cmd_tvalid,
        output m_axis_cmd_tready,
        output s_axis_sts_tdata,
        output s_axis_sts_tvalid,
        input  s_axis_sts_tready
    );
endinterface

// File: rtl/s2mm_cmd_sched.sv
// S2MM capture command scheduler: splits a region into chunked datamover commands,
// bounds the number in flight, retires them on status beats and reports done/error.
module s2mm_cmd_sched #(
    parameter int unsigned CHUNK_BYTES     = 4096,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                axis_st_clk,
    input  logic                axis_st_rstb,
    input  logic                write_start_i,
    input  logic                write_stop_i,
    input  logic                write_reset_i,
    input  logic                continuous_i,
    input  logic [31:0]         start_address_i,
    input  logic [31:0]         cap_size_i,
    s2mm_cmd_sched_if.master    dm,
    output logic                busy_o,
    output logic                cap_done_o,
    output logic                cap_err_o,
    output logic [7:0]          err_status_o,
    output logic [31:0]         cur_addr_o,
    output logic [15:0]         wrap_count_o,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [31:0] CHUNK32 = 32'(CHUNK_BYTES);
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] base_q, base_d;
    logic [31:0] size_q, size_d;
    logic        cont_q, cont_d;
    logic [3:0]  tag_q, tag_d;
    logic [3:0]  exp_tag_q, exp_tag_d;
    logic [3:0]  outst_q, outst_d;
    logic        stop_q, stop_d;
    logic        errp_q, errp_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  err_status_q, err_status_d;
    logic [15:0] wrap_q, wrap_d;

    logic        cmd_tvalid;
    logic        hs;
    logic        sts_acc;
    logic        sts_bad;
    logic        new_fail;
    logic        last;
    logic [22:0] btt;
    logic [7:0]  sts;

    // Presented command is a pure function of registers, so it cannot change while stalled
    assign sts        = dm.s_axis_sts_tdata;
    assign cmd_tvalid = (state_q == ISSUE) && (outst_q < MAX_OUT);
    assign btt        = (remaining_q < CHUNK32) ? remaining_q[22:0] : CHUNK32[22:0];
    assign last       = (remaining_q <= CHUNK32);
    assign hs         = cmd_tvalid && dm.m_axis_cmd_tready;
    assign sts_acc    = dm.s_axis_sts_tvalid && (outst_q != 4'd0);
    assign sts_bad    = !sts[7] || (|sts[6:4]) || (sts[3:0] != exp_tag_q);
    assign new_fail   = sts_acc && sts_bad && !err_q;

    assign dm.m_axis_cmd_tvalid = cmd_tvalid;
    assign dm.m_axis_cmd_tdata  = cmd_tvalid ?
        {4'h0, tag_q, cur_addr_q, 1'b0, 1'b1, 6'd0, 1'b1, btt} : 72'd0;
    assign dm.s_axis_sts_tready = 1'b1;

    assign busy_o       = (state_q == ISSUE) || (state_q == DRAIN);
    assign cap_done_o   = done_q;
    assign cap_err_o    = err_q;
    assign err_status_o = err_status_q;
    assign cur_addr_o   = cur_addr_q;
    assign wrap_count_o = wrap_q;
    assign dbg_state_o  = state_q;

    // State and datapath registers
    always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
        if (!axis_st_rstb) begin
            state_q      <= IDLE;
            cur_addr_q   <= 32'd0;
            remaining_q  <= 32'd0;
            base_q       <= 32'd0;
            size_q       <= 32'd0;
            cont_q       <= 1'b0;
            tag_q        <= 4'd0;
            exp_tag_q    <= 4'd0;
            outst_q      <= 4'd0;
            stop_q       <= 1'b0;
            errp_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_status_q <= 8'd0;
            wrap_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            base_q       <= base_d;
            size_q       <= size_d;
            cont_q       <= cont_d;
            tag_q        <= tag_d;
            exp_tag_q    <= exp_tag_d;
            outst_q      <= outst_d;
            stop_q       <= stop_d;
            errp_q       <= errp_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_status_q <= err_status_d;
            wrap_q       <= wrap_d;
        end
    end

    // Next-state: command bookkeeping, status retirement, FSM transitions, then abort
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        base_d       = base_q;
        size_d       = size_q;
        cont_d       = cont_q;
        tag_d        = tag_q;
        exp_tag_d    = exp_tag_q;
        stop_d       = stop_q;
        errp_d       = errp_q;
        done_d       = done_q;
        err_d        = err_q;
        err_status_d = err_status_q;
        wrap_d       = wrap_q;
        outst_d      = outst_q + {3'd0, hs} - {3'd0, sts_acc};

        if (sts_acc) begin
            exp_tag_d = exp_tag_q + 4'd1;
        end
        if (new_fail) begin
            err_d        = 1'b1;
            err_status_d = sts;
        end

        if (hs) begin
            tag_d = tag_q + 4'd1;
            if (last && cont_q) begin
                // Ring mode: restart at the base for the next pass
                cur_addr_d  = base_q;
                remaining_d = size_q;
                if (wrap_q != 16'hFFFF) begin
                    wrap_d = wrap_q + 16'd1;
                end
            end else begin
                cur_addr_d  = cur_addr_q + {9'd0, btt};
                remaining_d = remaining_q - {9'd0, btt};
            end
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (write_start_i) begin
                    base_d       = start_address_i;
                    size_d       = cap_size_i;
                    cont_d       = continuous_i;
                    cur_addr_d   = start_address_i;
                    remaining_d  = cap_size_i;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    err_status_d = 8'd0;
                    wrap_d       = 16'd0;
                    stop_d       = 1'b0;
                    errp_d       = 1'b0;
                    if (cap_size_i == 32'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (new_fail) begin
                    state_d = ERR;
                end
            end
            ISSUE: begin
                if (new_fail || errp_q) begin
                    // A stalled command must still complete before issuing stops
                    if (cmd_tvalid && !dm.m_axis_cmd_tready) begin
                        errp_d = 1'b1;
                    end else begin
                        errp_d  = 1'b0;
                        state_d = ERR;
                    end
                end else if (hs && last && !cont_q) begin
                    stop_d  = 1'b0;
                    state_d = DRAIN;
                end else if (stop_q || write_stop_i) begin
                    if (!cmd_tvalid || hs) begin
                        stop_d  = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (new_fail) begin
                    state_d = ERR;
                end else if (outst_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (write_reset_i) begin
            state_d      = IDLE;
            cur_addr_d   = 32'd0;
            remaining_d  = 32'd0;
            tag_d        = 4'd0;
            exp_tag_d    = 4'd0;
            outst_d      = 4'd0;
            stop_d       = 1'b0;
            errp_d       = 1'b0;
            done_d       = 1'b0;
            err_d        = 1'b0;
            err_status_d = 8'd0;
            wrap_d       = 16'd0;
        end
    end

endmodule
